seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//  Multi-cycle radix-2^STEPS shift-add multiplier for the EXU MULT/MULTU path.
//  Counterpart of the sequential divider: same valid/done/res contract, so the
//  EXU drives both with one sequencer.
//  Produces a 64-bit {HI,LO} product, optionally accumulated for MADD/MSUB.
// PARAMETERS
//  WIDTH  32  operand width; res is 2*WIDTH bits
//  STEPS  1   multiplier bits retired per cycle (1, 2 or 4; must divide WIDTH)
// PORTS
//  clk     in   1        clock
//  reset   in   1        synchronous, active-high
//  valid   in   1        start request; sampled only in IDLE
//  flush   in   1        pipeline kill; aborts an operation in flight
//  a       in   WIDTH    multiplicand
//  b       in   WIDTH    multiplier
//  sign    in   1        1 = two's-complement (MULT), 0 = unsigned (MULTU)
//  done    out  1        high while IDLE; res valid and stable
//  res     out  2*WIDTH  {HI,LO} result of the last completed operation
// BEHAVIOUR
//  Reset and priority
//  - Reset: state=IDLE, res=0, done=1. Priority: reset > flush > valid.
//  States
//  - IDLE: valid=1 -> latch |a|, |b|, neg=sign&(a[MSB]^b[MSB]), and sign.
//    Clear the 2*WIDTH accumulator. cnt=WIDTH/STEPS. Go to BUSY.
//  - BUSY: each cycle, repeat STEPS times: if mplr[0], acc+=mcand<<k;
//    then shift mplr right by 1. cnt--. When cnt reaches 1, go to FIX next.
//  - FIX: res <= neg ? -acc : acc (2*WIDTH two's complement). Go to IDLE.
//  Latency
//  - Accept edge E0. done=0 from E0. res updates and done=1 at edge
//    E0+WIDTH/STEPS+1 (33 cycles by default).
//  Handshake
//  - done = (state==IDLE), registered. valid in BUSY/FIX is ignored.
//  - valid on the first cycle done=1 is accepted (back-to-back, no bubble).
//  - Operands/sign are sampled only at accept and may change afterwards.
//  Arithmetic
//  - Magnitude = sign&x[MSB] ? ~x+1 : x, held in WIDTH bits unsigned.
//    -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
//  - Product of magnitudes always fits in 2*WIDTH bits; no overflow case.
//  - Unsigned mode never negates.
//  Boundaries
//  - flush in BUSY/FIX: IDLE next cycle, done=1, res keeps its previous value.
//  - flush in IDLE blocks a same-cycle valid.
//  - Reset mid-operation: IDLE, res=0. A zero operand still takes full latency.
// CONFIGURATION
//  MUL_ACC_EN defined:
//  - Adds ports acc_in (in, 2*WIDTH) and acc_op (in, 2): 00 none, 01 add
//    (MADD), 10 subtract (MSUB), 11 reserved = none. Both sampled at accept.
//  - FIX writes res <= acc_in +/- signed product, modulo 2^(2*WIDTH).
//  - Latency unchanged.
//  MUL_ACC_EN undefined: acc_in/acc_op ports absent; res = product only.
// TESTING
//  1 unsigned 0xFFFFFFFF*0xFFFFFFFF -> res=0xFFFFFFFE_00000001.
//    done low 33 cycles after accept.
//  2 signed -1*5 -> 0xFFFFFFFF_FFFFFFFB; signed 0x80000000*0x80000000 ->
//    0x40000000_00000000; unsigned 0x80000000*2 -> 0x00000001_00000000.
//  3 valid held during BUSY -> ignored, single completion. New valid on first
//    done=1 cycle (7*6) -> accepted; 42 after a further 33 cycles.
//  4 flush at cycle 10 of an op -> done=1 next cycle, res = prior result.
//    reset at cycle 10 -> done=1, res=0.
//  5 STEPS=4: 0x10000*0x10000 -> 0x00000001_00000000 with latency 9 cycles.
//  6 MUL_ACC_EN, signed 3*-2, acc_in=0x10: acc_op=01 -> 0xA; acc_op=10 -> 0x16.

Source files
------------

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier (radix 2^STEPS) producing a 2*WIDTH {HI,LO} product.
// Optional MADD/MSUB accumulation is enabled by defining MUL_ACC_EN.
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sign,
`ifdef MUL_ACC_EN
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [1:0]           acc_op,
`endif
  output logic                 done,
  output logic [2*WIDTH-1:0]   res
);

  localparam int                 NCYC     = WIDTH / STEPS;
  localparam int                 CNT_W    = $clog2(NCYC + 1);
  localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(NCYC);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, BUSY, FIX} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
`ifdef MUL_ACC_EN
  logic [2*WIDTH-1:0]   acc_in_q, acc_in_d;
  logic [1:0]           acc_op_q, acc_op_d;
`endif

  // -2^(WIDTH-1) negates onto itself, which is exactly 2^(WIDTH-1) read unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? ('0 - x) : x;
  endfunction

  always_comb begin
    logic [2*WIDTH-1:0] acc_v;
    logic [2*WIDTH-1:0] mc_v;
    logic [WIDTH-1:0]   mp_v;
    logic [2*WIDTH-1:0] prod;
    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    res_d    = res_q;
`ifdef MUL_ACC_EN
    acc_in_d = acc_in_q;
    acc_op_d = acc_op_q;
`endif
    acc_v    = acc_q;
    mc_v     = mcand_q;
    mp_v     = mplr_q;
    prod     = neg_q ? ('0 - acc_q) : acc_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (valid) begin
          mcand_d  = {{WIDTH{1'b0}}, magnitude(a, sign)};
          mplr_d   = magnitude(b, sign);
          neg_d    = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = CNT_INIT;
`ifdef MUL_ACC_EN
          acc_in_d = acc_in;
          acc_op_d = acc_op;
`endif
          state_d  = BUSY;
        end
        BUSY: begin
          for (int k = 0; k < STEPS; k++) begin
            if (mp_v[0]) acc_v = acc_v + mc_v;
            mc_v = mc_v << 1;
            mp_v = mp_v >> 1;
          end
          acc_d   = acc_v;
          mcand_d = mc_v;
          mplr_d  = mp_v;
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = FIX;
        end
        FIX: begin
`ifdef MUL_ACC_EN
          case (acc_op_q)
            2'b01:   res_d = acc_in_q + prod;
            2'b10:   res_d = acc_in_q - prod;
            default: res_d = prod;
          endcase
`else
          res_d = prod;
`endif
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
`ifdef MUL_ACC_EN
      acc_in_q <= '0;
      acc_op_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
`ifdef MUL_ACC_EN
      acc_in_q <= acc_in_d;
      acc_op_q <= acc_op_d;
`endif
    end
  end

  assign done = (state_q == IDLE);
  assign res  = res_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: STEPS=1 and STEPS=4 instances, hand-computed products.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset, valid, valid4, flush, sign;
  logic [31:0] a, b;
  logic        done, done4;
  logic [63:0] res, res4;
`ifdef MUL_ACC_EN
  logic [63:0] acc_in;
  logic [1:0]  acc_op;
`endif
  int          n_checks = 0;
  int          n_bad    = 0;
  int          lat;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(32), .STEPS(1)) u_dut (
    .clk(clk), .reset(reset), .valid(valid), .flush(flush),
    .a(a), .b(b), .sign(sign),
`ifdef MUL_ACC_EN
    .acc_in(acc_in), .acc_op(acc_op),
`endif
    .done(done), .res(res)
  );

  seq_multiplier #(.WIDTH(32), .STEPS(4)) u_dut4 (
    .clk(clk), .reset(reset), .valid(valid4), .flush(flush),
    .a(a), .b(b), .sign(sign),
`ifdef MUL_ACC_EN
    .acc_in(acc_in), .acc_op(acc_op),
`endif
    .done(done4), .res(res4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one operation and returns the cycles from the accept edge until done is seen high.
  task automatic run_op(input bit use4, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, output int cycles);
    @(negedge clk);
    a = av; b = bv; sign = sv;
    if (use4) valid4 = 1'b1; else valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; valid4 = 1'b0;
    cycles = 0;
    while (!(use4 ? done4 : done) && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; valid4 = 1'b0; flush = 1'b0; sign = 1'b0;
    a = '0; b = '0;
`ifdef MUL_ACC_EN
    acc_in = '0; acc_op = 2'b00;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_done",  64'(done),  64'd1);
    check("reset_res",   res,        64'd0);
    check("reset_done4", 64'(done4), 64'd1);

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check("umax_res", res, 64'hFFFF_FFFE_0000_0001);
    check("umax_lat", 64'(lat), 64'd33);

    run_op(1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, lat);
    check("neg1x5_res", res, 64'hFFFF_FFFF_FFFF_FFFB);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, lat);
    check("minxmin_res", res, 64'h4000_0000_0000_0000);
    run_op(1'b0, 32'h8000_0000, 32'd2, 1'b0, lat);
    check("u_msbx2_res", res, 64'h0000_0001_0000_0000);
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, lat);
    check("7xneg3_res", res, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(1'b0, 32'd0, 32'd5, 1'b1, lat);
    check("zero_res", res, 64'd0);
    check("zero_lat", 64'(lat), 64'd33);

    // valid held through BUSY, operands changed mid-flight, then back-to-back accept
    @(negedge clk);
    a = 32'd3; b = 32'd5; sign = 1'b0; valid = 1'b1;
    @(negedge clk);
    a = 32'd7; b = 32'd6;
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("hold_res", res, 64'd15);
    check("hold_lat", 64'(lat), 64'd33);
    @(negedge clk);
    valid = 1'b0;
    check("b2b_accepted", 64'(done), 64'd0);
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_res", res, 64'd42);
    check("b2b_lat", 64'(lat), 64'd33);

    // flush ten cycles into an operation
    @(negedge clk);
    a = 32'd9; b = 32'd9; sign = 1'b0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done", 64'(done), 64'd1);
    check("flush_res",  res, 64'd42);
    repeat (40) @(negedge clk);
    check("flush_res_later", res, 64'd42);

    // reset ten cycles into an operation
    @(negedge clk);
    a = 32'd9; b = 32'd9; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_done", 64'(done), 64'd1);
    check("midrst_res",  res, 64'd0);

    // flush in IDLE blocks a same-cycle valid
    @(negedge clk);
    a = 32'd2; b = 32'd2; valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    check("idle_flush_done", 64'(done), 64'd1);
    repeat (40) @(negedge clk);
    check("idle_flush_res", res, 64'd0);

    run_op(1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0, lat);
    check("s4_res", res4, 64'h0000_0001_0000_0000);
    check("s4_lat", 64'(lat), 64'd9);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, lat);
    check("s4_neg_res", res4, 64'hFFFF_FFFF_FFFF_FFFB);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check("s4_umax_res", res4, 64'hFFFF_FFFE_0000_0001);

`ifdef MUL_ACC_EN
    acc_in = 64'h10;
    acc_op = 2'b01;
    run_op(1'b0, 32'd3, 32'hFFFF_FFFE, 1'b1, lat);
    check("madd_res", res, 64'hA);
    check("madd_lat", 64'(lat), 64'd33);
    acc_op = 2'b10;
    run_op(1'b0, 32'd3, 32'hFFFF_FFFE, 1'b1, lat);
    check("msub_res", res, 64'h16);
    acc_op = 2'b11;
    run_op(1'b0, 32'd3, 32'hFFFF_FFFE, 1'b1, lat);
    check("accrsv_res", res, 64'hFFFF_FFFF_FFFF_FFFA);
    acc_op = 2'b00;
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
